parallel_mac_lanes: RTL and testbench

N-lane signed multiply-accumulate datapath paired with the parallel compute controller. After a start pulse it accepts exactly M operand beats. Each beat carries N activation/weight pairs. Each lane accumulates its M products, then the block presents the N sums on a valid/ready output and holds them until accepted. This block is the compute stage the controller's M-step count sequences.

---
 rtl/parallel_mac_lanes_if.sv | 30 +++
 rtl/parallel_mac_lanes.sv | 124 ++++++++++++
 tb/tb_parallel_mac_lanes.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parallel_mac_lanes_if.sv
// Operand/result handshake bundle for the parallel MAC lanes.
// The master drives the job start, operand beats and result acceptance.
// The slave (the MAC block) drives the ready/valid status and the lane sums.
interface parallel_mac_lanes_if #(
    parameter int Width = 8,
    parameter int N     = 4,
    parameter int M     = 3
);
    localparam int ACC_W = 2*Width + $clog2(M+1);

    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*Width-1:0]   act_in;
    logic [N*Width-1:0]   wgt_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*ACC_W-1:0]   acc_out;
    logic                 busy;

    modport master (
        output start, in_valid, act_in, wgt_in, out_ready,
        input  in_ready, out_valid, acc_out, busy
    );

    modport slave (
        input  start, in_valid, act_in, wgt_in, out_ready,
        output in_ready, out_valid, acc_out, busy
    );
endinterface

// File: rtl/parallel_mac_lanes.sv
// N-lane signed multiply-accumulate stage. A start in IDLE clears the lanes,
// exactly M operand beats are then accumulated, and the N sums are held on a
// valid/ready output until the consumer takes them.
module parallel_mac_lanes #(
    parameter int Width = 8,
    parameter int N     = 4,
    parameter int M     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    parallel_mac_lanes_if.slave   bus
);
    // Accumulator headroom covers M full-scale products, so no wrap/saturate.
    localparam int ACC_W = 2*Width + $clog2(M+1);
    localparam int PW    = 2*Width;
    localparam int CW    = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M-1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic                      r_busy;
    logic [N-1:0][ACC_W-1:0]   r_acc;

    logic [N-1:0][PW-1:0]      w_act;
    logic [N-1:0][PW-1:0]      w_wgt;
    logic [N-1:0][PW-1:0]      w_prod;
    logic [N-1:0][ACC_W-1:0]   w_ext;
    logic                      w_clear;
    logic                      w_accept;

    assign w_clear  = (r_state == IDLE) && bus.start;
    assign w_accept = r_in_ready && bus.in_valid;

    // Per-lane full-precision signed product, sign-extended to accumulator width.
    // Operands are widened first so the multiply is done at product width.
    always_comb begin
        w_act  = '0;
        w_wgt  = '0;
        w_prod = '0;
        w_ext  = '0;
        for (int i = 0; i < N; i++) begin
            w_act[i]  = {{Width{bus.act_in[i*Width + Width-1]}}, bus.act_in[i*Width +: Width]};
            w_wgt[i]  = {{Width{bus.wgt_in[i*Width + Width-1]}}, bus.wgt_in[i*Width +: Width]};
            w_prod[i] = PW'($signed(w_act[i]) * $signed(w_wgt[i]));
            w_ext[i]  = {{(ACC_W-PW){w_prod[i][PW-1]}}, w_prod[i]};
        end
    end

    // Lane accumulators: cleared on an honoured start, summed on accepted beats,
    // otherwise held (results persist after the output handshake).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_clear) begin
            r_acc <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                r_acc[i] <= r_acc[i] + w_ext[i];
            end
        end
    end

    // Job sequencer with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= ACCUM;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        if (r_cnt == LAST) begin
                            // Final beat: stop accepting, present sums next cycle.
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // start here is deliberately ignored; a new job needs IDLE.
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.acc_out   = r_acc;

endmodule

// File: tb/tb_parallel_mac_lanes.sv
// Randomized self-checking bench for parallel_mac_lanes. Expected lane sums
// come from a plain sum-of-products over the beats the bench itself offered.
module tb_parallel_mac_lanes;
    localparam int W     = 8;
    localparam int N     = 4;
    localparam int M     = 3;
    localparam int ACC_W = 2*W + $clog2(M+1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parallel_mac_lanes_if #(.Width(W), .N(N), .M(M)) bus ();

    parallel_mac_lanes #(.Width(W), .N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    int act_t [M][N];
    int wgt_t [M][N];

    function automatic int lane_out(input int i);
        logic [ACC_W-1:0] v;
        v = bus.acc_out[i*ACC_W +: ACC_W];
        return int'($signed(v));
    endfunction

    function automatic int ref_sum(input int i);
        int s = 0;
        for (int b = 0; b < M; b++) s += act_t[b][i] * wgt_t[b][i];
        return s;
    endfunction

    task automatic rand_beats();
        for (int b = 0; b < M; b++)
            for (int i = 0; i < N; i++) begin
                act_t[b][i] = int'($urandom_range(0, 255)) - 128;
                wgt_t[b][i] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic drive_beat(input int b);
        for (int i = 0; i < N; i++) begin
            bus.act_in[i*W +: W] = W'(act_t[b][i]);
            bus.wgt_in[i*W +: W] = W'(wgt_t[b][i]);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    // Offers n_beats beats (with an optional idle gap before beat gap_at) and
    // records what was observed; the calling test does the comparisons.
    task automatic feed(input int n_beats, input int gap_at, input int gap_len,
                        output int acc_n, output bit busy_ok, output bit early_ov);
        bit took;
        int guard;
        acc_n = 0; busy_ok = 1'b1; early_ov = 1'b0;
        for (int b = 0; b < n_beats; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus.in_valid = 1'b0;
                    bus.act_in   = $urandom;
                    bus.wgt_in   = $urandom;
                    @(posedge clk); #1;
                    if (!bus.busy) busy_ok = 1'b0;
                    if (bus.out_valid) early_ov = 1'b1;
                end
            end
            drive_beat(b);
            bus.in_valid = 1'b1;
            took = 1'b0; guard = 0;
            while (!took && guard < 20) begin
                took = bus.in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (took) acc_n++;
            if (b < n_beats-1 && bus.out_valid) early_ov = 1'b1;
            if (!bus.busy) busy_ok = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b expected 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", bus.busy); else n_pass++;
        n_total++; if (bus.acc_out !== '0) $display("FAIL reset_acc_out got %h expected 0", bus.acc_out); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_no_start_busy got %b expected 0", bus.busy); else n_pass++;
    endtask

    task automatic test_basic();
        int an; bit bok, eov;
        int exp_s [N] = '{3, 6, 9, 12};
        for (int b = 0; b < M; b++)
            for (int i = 0; i < N; i++) begin act_t[b][i] = 1; wgt_t[b][i] = i + 1; end
        pulse_start();
        n_total++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_after_start got %b expected 1", bus.busy); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL basic_in_ready got %b expected 1", bus.in_ready); else n_pass++;
        feed(M, -1, 0, an, bok, eov);
        n_total++; if (an !== M) $display("FAIL basic_beats got %0d expected %0d", an, M); else n_pass++;
        n_total++; if (eov !== 1'b0) $display("FAIL basic_early_valid got %b expected 0", eov); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_latency out_valid got %b expected 1", bus.out_valid); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL basic_hold_in_ready got %b expected 0", bus.in_ready); else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_total++; if (lane_out(i) !== exp_s[i]) $display("FAIL basic_sum lane%0d got %0d expected %0d", i, lane_out(i), exp_s[i]); else n_pass++;
        end
        handshake();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_done_valid got %b expected 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL basic_done_busy got %b expected 0", bus.busy); else n_pass++;
        n_total++; if (lane_out(3) !== 12) $display("FAIL basic_sum_retained got %0d expected 12", lane_out(3)); else n_pass++;
    endtask

    task automatic test_gap();
        int an; bit bok, eov;
        pulse_start();
        feed(M, 1, 2, an, bok, eov);
        n_total++; if (an !== M) $display("FAIL gap_beats got %0d expected %0d", an, M); else n_pass++;
        n_total++; if (bok !== 1'b1) $display("FAIL gap_busy got %b expected 1", bok); else n_pass++;
        n_total++; if (eov !== 1'b0) $display("FAIL gap_early_valid got %b expected 0", eov); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL gap_out_valid got %b expected 1", bus.out_valid); else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_total++; if (lane_out(i) !== 3*(i+1)) $display("FAIL gap_sum lane%0d got %0d expected %0d", i, lane_out(i), 3*(i+1)); else n_pass++;
        end
        handshake();
    endtask

    task automatic test_extremes();
        int an; bit bok, eov;
        int wv [2] = '{-128, 127};
        int ev [2] = '{49152, -48768};
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < M; b++)
                for (int i = 0; i < N; i++) begin act_t[b][i] = -128; wgt_t[b][i] = wv[k]; end
            pulse_start();
            feed(M, -1, 0, an, bok, eov);
            for (int i = 0; i < N; i++) begin
                n_total++; if (lane_out(i) !== ev[k]) $display("FAIL extreme%0d_sum lane%0d got %0d expected %0d", k, i, lane_out(i), ev[k]); else n_pass++;
            end
            handshake();
        end
    endtask

    task automatic test_hold();
        int an; bit bok, eov;
        bit stable = 1'b1;
        rand_beats();
        pulse_start();
        feed(M, -1, 0, an, bok, eov);
        for (int c = 0; c < 5; c++) begin
            bus.out_ready = 1'b0;
            bus.start     = 1'b1;
            bus.in_valid  = 1'b1;
            bus.act_in    = $urandom;
            bus.wgt_in    = $urandom;
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
            for (int i = 0; i < N; i++) if (lane_out(i) !== ref_sum(i)) stable = 1'b0;
        end
        bus.start = 1'b0; bus.in_valid = 1'b0;
        n_total++; if (stable !== 1'b1) $display("FAIL hold_stable got %b expected 1", stable); else n_pass++;
        handshake();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL hold_release_valid got %b expected 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL hold_release_busy got %b expected 0", bus.busy); else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_total++; if (lane_out(i) !== ref_sum(i)) $display("FAIL hold_sum lane%0d got %0d expected %0d", i, lane_out(i), ref_sum(i)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int an; bit bok, eov;
        bit never_valid = 1'b1;
        rand_beats();
        pulse_start();
        feed(2, -1, 0, an, bok, eov);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b expected 0", bus.busy); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready got %b expected 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.acc_out !== '0) $display("FAIL midrst_acc got %h expected 0", bus.acc_out); else n_pass++;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) never_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        n_total++; if (never_valid !== 1'b1) $display("FAIL midrst_no_valid got %b expected 1", never_valid); else n_pass++;
        rand_beats();
        pulse_start();
        feed(M, -1, 0, an, bok, eov);
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL midrst_fresh_valid got %b expected 1", bus.out_valid); else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_total++; if (lane_out(i) !== ref_sum(i)) $display("FAIL midrst_fresh_sum lane%0d got %0d expected %0d", i, lane_out(i), ref_sum(i)); else n_pass++;
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int an; bit bok, eov;
        rand_beats();
        pulse_start();
        feed(M, -1, 0, an, bok, eov);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL b2b_start_ignored busy got %b expected 0", bus.busy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_still_idle in_ready got %b expected 0", bus.in_ready); else n_pass++;
        rand_beats();
        pulse_start();
        n_total++; if (bus.acc_out !== '0) $display("FAIL b2b_cleared got %h expected 0", bus.acc_out); else n_pass++;
        feed(M, -1, 0, an, bok, eov);
        for (int i = 0; i < N; i++) begin
            n_total++; if (lane_out(i) !== ref_sum(i)) $display("FAIL b2b_sum lane%0d got %0d expected %0d", i, lane_out(i), ref_sum(i)); else n_pass++;
        end
        handshake();
    endtask

    task automatic test_random_jobs();
        int an; bit bok, eov;
        int gap_at, gap_len, hold_wait;
        for (int j = 0; j < 8; j++) begin
            rand_beats();
            gap_at    = int'($urandom_range(0, M));
            gap_len   = int'($urandom_range(0, 3));
            hold_wait = int'($urandom_range(0, 3));
            pulse_start();
            feed(M, gap_at, gap_len, an, bok, eov);
            n_total++; if (an !== M || eov !== 1'b0) $display("FAIL rand%0d_beats got %0d/%b expected %0d/0", j, an, eov, M); else n_pass++;
            repeat (hold_wait) begin @(posedge clk); #1; end
            n_total++; if (bus.out_valid !== 1'b1) $display("FAIL rand%0d_valid got %b expected 1", j, bus.out_valid); else n_pass++;
            for (int i = 0; i < N; i++) begin
                n_total++; if (lane_out(i) !== ref_sum(i)) $display("FAIL rand%0d_sum lane%0d got %0d expected %0d", j, i, lane_out(i), ref_sum(i)); else n_pass++;
            end
            handshake();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.act_in    = '0;
        bus.wgt_in    = '0;
        test_reset();
        test_basic();
        test_gap();
        test_extremes();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random_jobs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: %0d of %0d checks passed", n_pass, n_total);
        $fatal(1);
    end
endmodule
